// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory-stage sequencer: funct3 encodings,
// controller state encoding and op classification helpers.
package mem_access_ctrl_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Controller state encoding
  typedef enum logic [1:0] {
    MAC_IDLE = 2'b00,
    MAC_RD   = 2'b01,
    MAC_WR   = 2'b10,
    MAC_RESP = 2'b11
  } mac_state_e;

  // An op that must be answered with an error and never touch the bus
  function automatic logic op_illegal(input logic store, input logic [2:0] funct3,
                                      input logic xlen64);
    if (store) begin
      return funct3[2] || ((funct3 == F3_SD) && !xlen64);
    end
    return funct3 == 3'b111;
  endfunction

  // A store that covers the whole bus word and needs no read-modify-write
  function automatic logic op_full_store(input logic store, input logic [2:0] funct3,
                                         input logic xlen64);
    return store && (((funct3 == F3_SD) && xlen64) || ((funct3 == F3_SW) && !xlen64));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_lu.sv
// Load unit: selects the addressed lane of a bus word and extends it to XLEN.
module mem_access_ctrl_lu
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            s_byte_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] shifted;

  // Align the addressed byte to bit 0, then extend per funct3
  always_comb begin
    shifted = s_byte_i ? (rdata_i >> 8) : rdata_i;
    case (funct3_i)
      F3_LB:   result_o = XLEN'($signed(shifted[7:0]));
      F3_LH:   result_o = XLEN'($signed(shifted[15:0]));
      F3_LW:   result_o = XLEN'($signed(shifted[31:0]));
      F3_LBU:  result_o = XLEN'(shifted[7:0]);
      F3_LHU:  result_o = XLEN'(shifted[15:0]);
      F3_LWU:  result_o = XLEN'(shifted[31:0]);
      F3_LD:   result_o = shifted;
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl_su.sv
// Store unit: merges store data into a previously read bus word.
module mem_access_ctrl_su
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            s_byte_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] mask_base;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] data_sh;

  // Build a lane mask for the store width and splice the data in at s_byte
  always_comb begin
    case (funct3_i)
      F3_SB:   mask_base = XLEN'(8'hFF);
      F3_SH:   mask_base = XLEN'(16'hFFFF);
      F3_SW:   mask_base = XLEN'(32'hFFFF_FFFF);
      default: mask_base = '1;
    endcase
    mask     = s_byte_i ? (mask_base << 8) : mask_base;
    data_sh  = s_byte_i ? (wdata_i << 8) : wdata_i;
    result_o = (rdata_i & ~mask) | (data_sh & mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: runs one load/store at a time over a halfword
// addressed bus, using read-modify-write for partial stores.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            mem_ack_i
);

  localparam logic XLEN64 = (XLEN == 64);

  mac_state_e      state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            s_byte_q, s_byte_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rd_buf_q, rd_buf_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [XLEN-1:0] lu_result;
  logic [XLEN-1:0] su_result;

  // Load formatting of the word arriving on the bus this cycle
  mem_access_ctrl_lu #(.XLEN(XLEN)) u_lu (
    .s_byte_i (s_byte_q),
    .funct3_i (funct3_q),
    .rdata_i  (mem_rdata_i),
    .result_o (lu_result)
  );

  // Merge uses rd_buf_d so the write data is ready on the edge entering WR
  mem_access_ctrl_su #(.XLEN(XLEN)) u_su (
    .s_byte_i (s_byte_q),
    .funct3_i (funct3_q),
    .rdata_i  (rd_buf_d),
    .wdata_i  (wdata_q),
    .result_o (su_result)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    s_byte_d     = s_byte_q;
    wdata_d      = wdata_q;
    rd_buf_d     = rd_buf_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      MAC_IDLE: begin
        if (req_valid_i) begin
          store_d      = req_store_i;
          funct3_d     = req_funct3_i;
          s_byte_d     = req_addr_i[0];
          wdata_d      = req_wdata_i;
          mem_addr_d   = req_addr_i >> 1;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (op_illegal(req_store_i, req_funct3_i, XLEN64)) begin
            state_d      = MAC_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (op_full_store(req_store_i, req_funct3_i, XLEN64)) begin
            state_d     = MAC_WR;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata_i;
          end else begin
            state_d   = MAC_RD;
            mem_req_d = 1'b1;
            mem_we_d  = 1'b0;
          end
        end
      end
      MAC_RD: begin
        if (mem_ack_i) begin
          rd_buf_d = mem_rdata_i;
          if (store_q) begin
            state_d     = MAC_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = su_result;
          end else begin
            state_d      = MAC_RESP;
            mem_req_d    = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = lu_result;
          end
        end
      end
      MAC_WR: begin
        if (mem_ack_i) begin
          state_d      = MAC_RESP;
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
        end
      end
      MAC_RESP: begin
        if (resp_ready_i) begin
          state_d      = MAC_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = MAC_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= MAC_IDLE;
      store_q      <= 1'b0;
      funct3_q     <= 3'b000;
      s_byte_q     <= 1'b0;
      wdata_q      <= '0;
      rd_buf_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      s_byte_q     <= s_byte_d;
      wdata_q      <= wdata_d;
      rd_buf_q     <= rd_buf_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Ready is a decode of IDLE, held low while reset is asserted
  assign req_ready_o  = (state_q == MAC_IDLE) && !rst_i;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (XLEN=32) with a byte-level
// memory/op reference model and a randomized bus responder.
module tb_mem_access_ctrl;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem_model [logic [31:0]];

  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  int          last_cyc;
  int          last_req_cycles;

  mem_access_ctrl #(.XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // XLEN=32: SD and funct3>=4 stores, and load funct3=7, are errors
  function automatic logic ref_illegal(input logic st, input logic [2:0] f3);
    if (st) return f3 >= 3'd3;
    return f3 == 3'd7;
  endfunction

  // Load value from arithmetic on the bus word: drop s bytes, keep nb bytes, extend
  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                           input logic s);
    longint v;
    longint span;
    int     nb;
    bit     sgn;
    v = longint'(word);
    if (s) v = v / 256;
    case (f3)
      3'd0:    begin nb = 1; sgn = 1'b1; end
      3'd1:    begin nb = 2; sgn = 1'b1; end
      3'd2:    begin nb = 4; sgn = 1'b1; end
      3'd4:    begin nb = 1; sgn = 1'b0; end
      3'd5:    begin nb = 2; sgn = 1'b0; end
      default: begin nb = 4; sgn = 1'b0; end
    endcase
    span = longint'(1) << (8 * nb);
    v = v % span;
    if (sgn && (v >= span / 2)) v = v - span;
    return 32'(v);
  endfunction

  // Store merge as byte replacement in the addressed word
  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [2:0] f3,
                                            input logic s, input logic [31:0] wd);
    logic [7:0] b [4];
    int nb;
    for (int i = 0; i < 4; i++) b[i] = word[8*i +: 8];
    nb = (f3 == 3'd0) ? 1 : ((f3 == 3'd1) ? 2 : 4);
    for (int k = 0; k < nb; k++) begin
      if (int'(s) + k < 4) b[int'(s) + k] = wd[8*k +: 8];
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One complete op: issue, serve the bus with dly wait cycles per request,
  // hold resp_ready low for rdly cycles, and check everything against the model
  task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int dly, input int rdly);
    logic [31:0] haddr, word, exp_rd, exp_wr;
    logic        s, exp_err, full, busy, done;
    int          exp_nrd, exp_nwr, exp_cyc;
    int          cyc, wcnt, nrd, nwr, reqc;
    logic [31:0] c_addr, c_wdata;
    logic        c_we;

    haddr   = addr >> 1;
    s       = addr[0];
    word    = rd_word(haddr);
    exp_err = ref_illegal(st, f3);
    full    = st && (f3 == 3'd2) && !exp_err;
    exp_rd  = (!st && !exp_err) ? ref_load(word, f3, s) : 32'h0;
    exp_wr  = full ? wd : ref_store(word, f3, s, wd);
    exp_nrd = (exp_err || full) ? 0 : 1;
    exp_nwr = (!exp_err && st) ? 1 : 0;
    exp_cyc = exp_err ? 1 : (exp_nrd + exp_nwr) * (dly + 1) + 1;

    @(negedge clk);
    chk_eq({tag, " req_ready"}, 64'(req_ready), 64'(1));
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ack    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_wdata  = $urandom;
    req_addr   = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));

    cyc = 1; busy = 1'b0; done = 1'b0; wcnt = 0; nrd = 0; nwr = 0; reqc = 0;
    c_addr = '0; c_wdata = '0; c_we = 1'b0;
    while (!done && cyc < 60) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (resp_valid) begin
        done = 1'b1;
        last_cyc   = cyc;
        last_rdata = resp_rdata;
        chk_eq({tag, " resp_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk_eq({tag, " resp_rdata"}, 64'(resp_rdata), 64'(exp_rd));
        chk_eq({tag, " resp_err"}, 64'(resp_err), 64'(exp_err));
        for (int h = 0; h < rdly; h++) begin
          mem_ack = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk_eq({tag, " hold_valid"}, 64'(resp_valid), 64'(1));
          chk_eq({tag, " hold_rdata"}, 64'(resp_rdata), 64'(exp_rd));
          chk_eq({tag, " hold_err"}, 64'(resp_err), 64'(exp_err));
          chk_eq({tag, " hold_mem_req"}, 64'(mem_req), 64'(0));
        end
        resp_ready = 1'b1;
        mem_ack    = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        chk_eq({tag, " valid_clear"}, 64'(resp_valid), 64'(0));
        chk_eq({tag, " ready_back"}, 64'(req_ready), 64'(1));
        chk_eq({tag, " mem_req_idle"}, 64'(mem_req), 64'(0));
      end else begin
        if (mem_req) begin
          reqc++;
          if (!busy) begin
            busy    = 1'b1;
            wcnt    = 0;
            c_addr  = mem_addr;
            c_we    = mem_we;
            c_wdata = mem_wdata;
            if (mem_we) begin
              nwr++;
              last_wdata = mem_wdata;
              chk_eq({tag, " wdata"}, 64'(mem_wdata), 64'(exp_wr));
            end else begin
              nrd++;
            end
            chk_eq({tag, " mem_addr"}, 64'(mem_addr), 64'(haddr));
          end else begin
            wcnt++;
            chk_eq({tag, " stable_addr"}, 64'(mem_addr), 64'(c_addr));
            chk_eq({tag, " stable_we"}, 64'(mem_we), 64'(c_we));
            chk_eq({tag, " stable_wdata"}, 64'(mem_wdata), 64'(c_wdata));
          end
          if (wcnt == dly) begin
            mem_ack = 1'b1;
            busy    = 1'b0;
            if (!mem_we) mem_rdata = word;
          end
        end else begin
          busy = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    chk_eq({tag, " completed"}, 64'(done), 64'(1));
    chk_eq({tag, " n_reads"}, 64'(nrd), 64'(exp_nrd));
    chk_eq({tag, " n_writes"}, 64'(nwr), 64'(exp_nwr));
    last_req_cycles = reqc;
    if (exp_nwr != 0) mem_model[haddr] = exp_wr;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    last_rdata = '0; last_wdata = '0; last_cyc = 0; last_req_cycles = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk_eq("rst req_ready", 64'(req_ready), 64'(0));
    chk_eq("rst resp_valid", 64'(resp_valid), 64'(0));
    chk_eq("rst resp_rdata", 64'(resp_rdata), 64'(0));
    chk_eq("rst resp_err", 64'(resp_err), 64'(0));
    chk_eq("rst mem_req", 64'(mem_req), 64'(0));
    chk_eq("rst mem_we", 64'(mem_we), 64'(0));
    chk_eq("rst mem_addr", 64'(mem_addr), 64'(0));
    chk_eq("rst mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;
    #1;
    chk_eq("post_rst req_ready", 64'(req_ready), 64'(1));

    // LB sign-extends the low lane
    mem_model[32'h8] = 32'h1234_80FF;
    run_op("lb", 1'b0, 3'b000, 32'h10, 32'h0, 0, 0);
    chk_eq("lb value", 64'(last_rdata), 64'(32'hFFFF_FFFF));
    chk_eq("lb cycle", 64'(last_cyc), 64'(2));

    // LBU takes the upper lane for an odd address
    run_op("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 0, 0);
    chk_eq("lbu value", 64'(last_rdata), 64'(32'h0000_0080));

    // SB read-modify-write
    mem_model[32'h8] = 32'h1234_5678;
    run_op("sb", 1'b1, 3'b000, 32'h11, 32'h0000_00AB, 0, 0);
    chk_eq("sb wdata", 64'(last_wdata), 64'(32'h1234_AB78));
    chk_eq("sb cycle", 64'(last_cyc), 64'(3));

    // Full-width SW with a slow bus
    run_op("sw", 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, 3, 0);
    chk_eq("sw wdata", 64'(last_wdata), 64'(32'hDEAD_BEEF));
    chk_eq("sw req_cycles", 64'(last_req_cycles), 64'(4));
    chk_eq("sw cycle", 64'(last_cyc), 64'(5));

    // Illegal load funct3 with a stalled consumer
    run_op("lerr", 1'b0, 3'b111, 32'h22, 32'h0, 0, 5);
    chk_eq("lerr cycle", 64'(last_cyc), 64'(1));

    // Reset in the read phase of an SH
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
    req_addr = 32'h21; req_wdata = 32'h0000_CAFE; mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk_eq("rstmid rd_req", 64'(mem_req), 64'(1));
    chk_eq("rstmid rd_we", 64'(mem_we), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("rstmid mem_req", 64'(mem_req), 64'(0));
    chk_eq("rstmid req_ready", 64'(req_ready), 64'(1));
    chk_eq("rstmid resp_valid", 64'(resp_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_eq("rstmid no_write", 64'(mem_req || mem_we), 64'(0));
    end
    mem_ack = 1'b0;
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h21, 32'h0, 1, 1);

    // Randomized ops over a small address window
    for (int n = 0; n < 60; n++) begin
      run_op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h100 + 32'($urandom_range(0, 15)), $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
